// File: rtl/btb_predictor.sv
// Branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational from stored state. Resolved branches and jumps
// write back through the update port.
// Optional: define BTB_BYPASS_EN to forward a same-cycle update to a lookup
// of the same PC.
module btb_predictor #(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned WORD_SIZE  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] pc,
  output logic [WORD_SIZE-1:0] pred_next_pc,
  output logic                 pred_taken,
  output logic                 pred_hit,
  input  logic                 upd_valid,
  input  logic [WORD_SIZE-1:0] upd_pc,
  input  logic                 upd_is_cond,
  input  logic                 upd_taken,
  input  logic [WORD_SIZE-1:0] upd_target,
  output logic [WORD_SIZE-1:0] mispred_cnt
);

  localparam int unsigned Entries = 1 << INDEX_BITS;
  localparam int unsigned TagBits = WORD_SIZE - INDEX_BITS;

  logic                 valid_q  [Entries];
  logic [TagBits-1:0]   tag_q    [Entries];
  logic [WORD_SIZE-1:0] target_q [Entries];
  logic [1:0]           ctr_q    [Entries];
  logic [WORD_SIZE-1:0] mispred_cnt_q;

  logic [INDEX_BITS-1:0] u_idx;
  logic [TagBits-1:0]    u_tag;
  logic                  u_hit;
  logic                  u_old_taken;
  logic                  u_eff_taken;
  logic                  u_mispred;
  logic                  u_we;
  logic                  u_new_valid;
  logic [TagBits-1:0]    u_new_tag;
  logic [WORD_SIZE-1:0]  u_new_target;
  logic [1:0]            u_new_ctr;

  logic [INDEX_BITS-1:0] l_idx;
  logic [TagBits-1:0]    l_tag;
  logic                  l_valid;
  logic [TagBits-1:0]    l_tag_st;
  logic [WORD_SIZE-1:0]  l_target;
  logic [1:0]            l_ctr;

  // Next-state of the entry addressed by the update port, plus misprediction.
  // When nothing is written the new_* fields equal the stored ones.
  always_comb begin
    u_idx        = upd_pc[INDEX_BITS-1:0];
    u_tag        = upd_pc[WORD_SIZE-1:INDEX_BITS];
    u_hit        = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    u_old_taken  = u_hit && ctr_q[u_idx][1];
    u_eff_taken  = upd_taken || !upd_is_cond;
    u_mispred    = upd_valid && ((u_old_taken != u_eff_taken) ||
                   (u_old_taken && (target_q[u_idx] != upd_target)));
    u_we         = 1'b0;
    u_new_valid  = valid_q[u_idx];
    u_new_tag    = tag_q[u_idx];
    u_new_target = target_q[u_idx];
    u_new_ctr    = ctr_q[u_idx];
    if (upd_valid) begin
      if (u_hit) begin
        u_we = 1'b1;
        if (!upd_is_cond) begin
          u_new_ctr    = 2'b11;
          u_new_target = upd_target;
        end else if (upd_taken) begin
          u_new_ctr    = (ctr_q[u_idx] == 2'b11) ? 2'b11 : ctr_q[u_idx] + 2'd1;
          u_new_target = upd_target;
        end else begin
          u_new_ctr    = (ctr_q[u_idx] == 2'b00) ? 2'b00 : ctr_q[u_idx] - 2'd1;
        end
      end else if (u_eff_taken) begin
        // Allocate on a taken miss; a not-taken miss leaves the entry alone.
        u_we         = 1'b1;
        u_new_valid  = 1'b1;
        u_new_tag    = u_tag;
        u_new_target = upd_target;
        u_new_ctr    = upd_is_cond ? 2'b10 : 2'b11;
      end
    end
  end

  // Table and counter state; reset wins over a same-cycle update.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q       <= '{default: 1'b0};
      ctr_q         <= '{default: 2'b01};
      mispred_cnt_q <= '0;
    end else begin
      if (u_we) begin
        valid_q[u_idx]  <= u_new_valid;
        tag_q[u_idx]    <= u_new_tag;
        target_q[u_idx] <= u_new_target;
        ctr_q[u_idx]    <= u_new_ctr;
      end
      if (u_mispred) begin
        mispred_cnt_q <= mispred_cnt_q + WORD_SIZE'(1);
      end
    end
  end

  // Lookup of the fetch PC, optionally seeing the in-flight update.
  always_comb begin
    l_idx    = pc[INDEX_BITS-1:0];
    l_tag    = pc[WORD_SIZE-1:INDEX_BITS];
    l_valid  = valid_q[l_idx];
    l_tag_st = tag_q[l_idx];
    l_target = target_q[l_idx];
    l_ctr    = ctr_q[l_idx];
`ifdef BTB_BYPASS_EN
    if (upd_valid && (upd_pc == pc)) begin
      l_valid  = u_new_valid;
      l_tag_st = u_new_tag;
      l_target = u_new_target;
      l_ctr    = u_new_ctr;
    end
`endif
    pred_hit     = l_valid && (l_tag_st == l_tag);
    pred_taken   = pred_hit && l_ctr[1];
    pred_next_pc = pred_taken ? l_target : pc + WORD_SIZE'(1);
  end

  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_btb_predictor.sv
// Scoreboard bench for btb_predictor: stimulus pushes expected lookup
// results computed from an abstract table model; a monitor pops and compares.
module tb_btb_predictor;

  logic        clk;
  logic        reset;
  logic [15:0] pc;
  logic [15:0] pred_next_pc;
  logic        pred_taken;
  logic        pred_hit;
  logic        upd_valid;
  logic [15:0] upd_pc;
  logic        upd_is_cond;
  logic        upd_taken;
  logic [15:0] upd_target;
  logic [15:0] mispred_cnt;

  btb_predictor #(
    .INDEX_BITS(4),
    .WORD_SIZE (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .pred_next_pc(pred_next_pc),
    .pred_taken  (pred_taken),
    .pred_hit    (pred_hit),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_is_cond (upd_is_cond),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .mispred_cnt (mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit valid;
    int tag;
    int target;
    int ctr;
  } ent_t;

  typedef struct {
    bit          chk;
    int          id;
    logic [15:0] pc;
    logic        hit;
    logic        taken;
    logic [15:0] npc;
    logic [15:0] cnt;
  } exp_t;

  ent_t m [16];
  int   m_cnt;
  exp_t exp_q [$];
  int   n_vec;
  int   n_err;
  int   n_item;

  function automatic ent_t next_entry(ent_t e, int upc, bit cond, bit taken, int tgt);
    ent_t r;
    bit   hit;
    r   = e;
    hit = e.valid && (e.tag == upc / 16);
    if (hit) begin
      if (!cond) begin
        r.ctr    = 3;
        r.target = tgt;
      end else if (taken) begin
        r.ctr    = (e.ctr < 3) ? e.ctr + 1 : 3;
        r.target = tgt;
      end else begin
        r.ctr = (e.ctr > 0) ? e.ctr - 1 : 0;
      end
    end else if (taken || !cond) begin
      r.valid  = 1'b1;
      r.tag    = upc / 16;
      r.target = tgt;
      r.ctr    = cond ? 2 : 3;
    end
    return r;
  endfunction

  function automatic bit is_mispred(ent_t e, int upc, bit cond, bit taken, int tgt);
    bit old_t;
    bit eff;
    old_t = e.valid && (e.tag == upc / 16) && (e.ctr >= 2);
    eff   = taken || !cond;
    return (old_t != eff) || (old_t && eff && (e.target != tgt));
  endfunction

  // One clock: drive inputs, queue the expected lookup, then advance the model.
  task automatic cycle(input bit rst, input int lpc, input bit uv, input int upc,
                       input bit cond, input bit tk, input int tgt, input bit chk);
    exp_t x;
    ent_t e;
    @(negedge clk);
    reset       = rst;
    pc          = 16'(lpc);
    upd_valid   = uv;
    upd_pc      = 16'(upc);
    upd_is_cond = cond;
    upd_taken   = tk;
    upd_target  = 16'(tgt);
    e = m[lpc % 16];
`ifdef BTB_BYPASS_EN
    if (uv && (upc == lpc)) e = next_entry(e, upc, cond, tk, tgt);
`endif
    x.chk   = chk;
    x.id    = n_item;
    x.pc    = 16'(lpc);
    x.hit   = e.valid && (e.tag == lpc / 16);
    x.taken = x.hit && (e.ctr >= 2);
    x.npc   = x.taken ? 16'(e.target) : 16'((lpc + 1) % 65536);
    x.cnt   = 16'(m_cnt);
    exp_q.push_back(x);
    n_item++;
    @(posedge clk);
    if (rst) begin
      foreach (m[i]) begin
        m[i].valid = 1'b0;
        m[i].ctr   = 1;
      end
      m_cnt = 0;
    end else if (uv) begin
      if (is_mispred(m[upc % 16], upc, cond, tk, tgt)) m_cnt = (m_cnt + 1) % 65536;
      m[upc % 16] = next_entry(m[upc % 16], upc, cond, tk, tgt);
    end
  endtask

  task automatic look(input int lpc);
    cycle(1'b0, lpc, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
  endtask

  task automatic upd(input int upc, input bit cond, input bit tk, input int tgt);
    cycle(1'b0, upc, 1'b1, upc, cond, tk, tgt, 1'b1);
  endtask

  // Monitor: outputs are always presented; compare every queued expectation.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #2;
      while (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        if (x.chk) begin
          n_vec++;
          if (pred_hit !== x.hit) begin
            n_err++;
            $display("FAIL hit item=%0d pc=%h got=%b want=%b", x.id, x.pc, pred_hit, x.hit);
          end
          n_vec++;
          if (pred_taken !== x.taken) begin
            n_err++;
            $display("FAIL taken item=%0d pc=%h got=%b want=%b", x.id, x.pc, pred_taken,
                     x.taken);
          end
          n_vec++;
          if (pred_next_pc !== x.npc) begin
            n_err++;
            $display("FAIL next_pc item=%0d pc=%h got=%h want=%h", x.id, x.pc, pred_next_pc,
                     x.npc);
          end
          n_vec++;
          if (mispred_cnt !== x.cnt) begin
            n_err++;
            $display("FAIL mispred_cnt item=%0d pc=%h got=%0d want=%0d", x.id, x.pc,
                     mispred_cnt, x.cnt);
          end
        end
      end
    end
  end

  initial begin
    int hi_tab [3];
    int lpc;
    int upc;
    bit uv;
    hi_tab = '{0, 1, 4095};
    n_vec  = 0;
    n_err  = 0;
    n_item = 0;
    m_cnt  = 0;
    foreach (m[i]) m[i] = '{valid: 1'b0, tag: 0, target: 0, ctr: 1};
    reset = 1'b1; pc = '0; upd_valid = 1'b0; upd_pc = '0;
    upd_is_cond = 1'b0; upd_taken = 1'b0; upd_target = '0;

    cycle(1'b1, 16'h0010, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    look(16'h0010);                        // miss after reset
    upd(16'h0010, 1'b1, 1'b1, 16'h0040);   // cond taken allocate, ctr 10
    look(16'h0010);                        // hit, taken, 0x40, cnt 1
    upd(16'h0010, 1'b1, 1'b0, 0);          // 10 -> 01
    upd(16'h0010, 1'b1, 1'b0, 0);          // 01 -> 00
    look(16'h0010);                        // not taken, 0x11
    upd(16'h0010, 1'b1, 1'b1, 16'h0040);
    upd(16'h0010, 1'b1, 1'b1, 16'h0040);
    upd(16'h0010, 1'b1, 1'b1, 16'h0040);   // saturates at 11
    upd(16'h0010, 1'b1, 1'b0, 0);          // 11 -> 10, still taken
    look(16'h0010);
    upd(16'h0013, 1'b0, 1'b0, 16'h0080);   // jump allocate
    look(16'h0003);                        // same index, other tag
    look(16'h0013);
    look(16'hFFFF);                        // wrap to 0
    cycle(1'b1, 16'h0020, 1'b1, 16'h0020, 1'b1, 1'b1, 16'h0099, 1'b1);
    look(16'h0020);                        // reset dropped the update
    look(16'h0010);
    cycle(1'b0, 16'h0030, 1'b1, 16'h0030, 1'b0, 1'b0, 16'h0055, 1'b1);
    look(16'h0030);

    for (int k = 0; k < 2000; k++) begin
      lpc = hi_tab[$urandom_range(0, 2)] * 16 + int'($urandom_range(0, 15));
      upc = hi_tab[$urandom_range(0, 2)] * 16 + int'($urandom_range(0, 15));
      uv  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) upc = lpc;
      cycle(($urandom_range(0, 99) == 0), lpc, uv, upc, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 3)) * 16'h1111, 1'b1);
    end

    @(negedge clk);
    #5;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
